// File: rtl/mem_bus_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_sink_if
// Brief    : Control strobes, datapath bus and SRAM port bundle for mem_bus_sink.
// Revision : 1.0
// ============================================================================
interface mem_bus_sink_if #(
    parameter int ADDR_W = 16
) ();
    logic [15:0]       bus_in;
    logic              LD_MAR;
    logic              LD_MDR;
    logic              MIO_EN;
    logic              rd_req;
    logic              wr_req;
    logic [15:0]       mem_rdata;
    logic              mem_ready;
    logic [ADDR_W-1:0] MAR;
    logic [15:0]       MDR;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ce_n;
    logic              mem_we_n;
    logic              mem_oe_n;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  bus_in, LD_MAR, LD_MDR, MIO_EN, rd_req, wr_req, mem_rdata, mem_ready,
        output MAR, MDR, mem_addr, mem_wdata, mem_ce_n, mem_we_n, mem_oe_n, busy, done, err
    );

    modport master (
        output bus_in, LD_MAR, LD_MDR, MIO_EN, rd_req, wr_req, mem_rdata, mem_ready,
        input  MAR, MDR, mem_addr, mem_wdata, mem_ce_n, mem_we_n, mem_oe_n, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_sink.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_sink
// Brief    : LC-3 MAR/MDR capture and SRAM read/write sequencer.
//            Optional wait-state abort enabled by defining MEM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module mem_bus_sink #(
    parameter int ADDR_W   = 16,
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 64
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    mem_bus_sink_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RD_CAP  = 3'd2,
        S_WR_WAIT = 3'd3,
        S_WR_END  = 3'd4
    } state_t;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_MAX = (MIN_WAIT - 1 > TIMEOUT - 2) ? MIN_WAIT - 1 : TIMEOUT - 2;
`else
    localparam int CNT_MAX = MIN_WAIT - 1;
`endif
    localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(MIN_WAIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_sat   = CNT_W'(CNT_MAX);
    localparam logic [15:0]      c_exc_code  = 16'h003C;
`ifdef MEM_TIMEOUT_EN
    // Abort on the edge where the counter would step onto TIMEOUT-1.
    localparam logic [CNT_W-1:0] c_abort_at  = CNT_W'(TIMEOUT - 2);
`endif

    if (MIN_WAIT < 1) begin : g_bad_min_wait
        $error("mem_bus_sink: MIN_WAIT must be >= 1");
    end
    if (TIMEOUT < 3) begin : g_bad_timeout
        $error("mem_bus_sink: TIMEOUT must be >= 3");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q,   mar_d;
    logic [15:0]       mdr_q,   mdr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              ce_n_q,  ce_n_d;
    logic              we_n_q,  we_n_d;
    logic              oe_n_q,  oe_n_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
`ifdef MEM_TIMEOUT_EN
    logic              err_q,   err_d;
`endif

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
`ifdef MEM_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // Loads land on the same edge the access starts, so it sees them.
                if (bus.LD_MAR) mar_d = bus.bus_in[ADDR_W-1:0];
                if (bus.LD_MDR && !bus.MIO_EN) mdr_d = bus.bus_in;
                if (bus.rd_req)      state_d = S_RD_WAIT;
                else if (bus.wr_req) state_d = S_WR_WAIT;
            end
            S_RD_WAIT, S_WR_WAIT: begin
                if (cnt_q >= c_wait_last && bus.mem_ready) begin
                    if (state_q == S_RD_WAIT) begin
                        state_d = S_RD_CAP;
                        mdr_d   = bus.mem_rdata;
                    end else begin
                        state_d = S_WR_END;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q >= c_abort_at) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    if (state_q == S_RD_WAIT) mdr_d = c_exc_code;
                end
`endif
                else if (cnt_q != c_cnt_sat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_CAP, S_WR_END: state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) cnt_d = '0;

        // Strobes are decoded from the next state and registered.
        ce_n_d = !(state_d == S_RD_WAIT || state_d == S_WR_WAIT);
        oe_n_d = (state_d != S_RD_WAIT);
        we_n_d = (state_d != S_WR_WAIT);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_RD_CAP || state_d == S_WR_END);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            ce_n_q  <= ce_n_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MEM_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.MAR       = mar_q;
    assign bus.mem_addr  = mar_q;
    assign bus.MDR       = mdr_q;
    assign bus.mem_wdata = mdr_q;
    assign bus.mem_ce_n  = ce_n_q;
    assign bus.mem_we_n  = we_n_q;
    assign bus.mem_oe_n  = oe_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef MEM_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
`default_nettype wire
